seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the team's fixed single-input sequence-detector FSM.
- Pattern length is set by parameter. The pattern is loaded at runtime, and overlapping/non-overlapping detection is selectable.
- Consumes a qualified serial bit stream, produces a registered one-cycle match pulse, and keeps a saturating match counter.
- Sits after bit-serial receive logic in lab datapaths.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/sat_counter.sv | 25 ++
 rtl/seq_detector_param.sv | 91 +++++++++
 tb/tb_seq_detector_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and widths for the parametrised serial sequence detector.
package seq_det_pkg;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 16;

    // Wide enough to count up to PAT_LEN for every legal pattern length.
    localparam int unsigned FILL_W = $clog2(PAT_LEN_MAX + 1);

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        FILL    = 2'd1,
        HUNT    = 2'd2
    } state_t;

    function automatic int unsigned fill_width(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_b,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    assign sat = &q;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && !sat) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loaded pattern, selectable overlap
// and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic               load_pat,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap_en,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               armed,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    state_t               state;
    logic [PAT_LEN-1:0]   pat_q;
    logic [PAT_LEN-1:0]   hist;
    logic [FILL_W-1:0]    fill;

    logic                 accept;
    logic [PAT_LEN-1:0]   hist_n;
    logic [FILL_W-1:0]    fill_n;
    logic                 fill_done;
    logic                 cmp_en;
    logic                 hit;

    // A bit is taken only when armed and not pre-empted by a reload.
    always_comb begin
        accept    = in_valid && (state != UNARMED) && !load_pat;
        hist_n    = {hist[PAT_LEN-2:0], in_bit};
        fill_n    = fill + FILL_W'(1);
        fill_done = (state == FILL) && (fill_n == FILL_W'(PAT_LEN));
        cmp_en    = (state == HUNT) || fill_done;
        hit       = accept && cmp_en && (hist_n == pat_q);
    end

    assign armed = (state != UNARMED);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= UNARMED;
            pat_q <= '0;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (load_pat) begin
            state <= FILL;
            pat_q <= pattern;
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (accept) begin
                if (hit && !overlap_en) begin
                    // Non-overlapping: the next match needs a full fresh window.
                    state <= FILL;
                    hist  <= '0;
                    fill  <= '0;
                end else begin
                    hist <= hist_n;
                    if (state == FILL) begin
                        fill <= fill_n;
                        if (fill_done) begin
                            state <= HUNT;
                        end
                    end
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock   (clock),
        .reset_b (reset_b),
        .clear   (load_pat),
        .inc     (hit),
        .q       (match_count),
        .sat     (count_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param with a small narrow-counter build.
module tb_seq_detector_param;

    localparam int unsigned PAT_LEN = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clock = 1'b0;
    logic               reset_b;
    logic               load_pat;
    logic [PAT_LEN-1:0] pattern;
    logic               overlap_en;
    logic               in_valid;
    logic               in_bit;
    logic               armed;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    always #5 clock = ~clock;

    seq_detector_param #(
        .PAT_LEN (PAT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset_b     (reset_b),
        .load_pat    (load_pat),
        .pattern     (pattern),
        .overlap_en  (overlap_en),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .armed       (armed),
        .match       (match),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    typedef struct {
        logic match;
        int   cnt;
        logic sat;
        logic armed;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 unarmed, 1 filling, 2 hunting.
    int               m_state;
    logic [PAT_LEN-1:0] m_pat;
    logic [PAT_LEN-1:0] m_hist;
    int               m_fill;
    int               m_cnt;
    logic             m_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pat   = '0;
        m_hist  = '0;
        m_fill  = 0;
        m_cnt   = 0;
        m_match = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic [PAT_LEN-1:0] p,
                              input logic ov, input logic v, input logic b);
        logic [PAT_LEN-1:0] nh;
        bit full;
        if (l) begin
            m_pat   = p;
            m_hist  = '0;
            m_fill  = 0;
            m_cnt   = 0;
            m_match = 1'b0;
            m_state = 1;
        end else begin
            m_match = 1'b0;
            if (v && m_state != 0) begin
                nh   = {m_hist[PAT_LEN-2:0], b};
                full = (m_state == 2) || (m_fill + 1 == PAT_LEN);
                if (full && nh == m_pat) begin
                    m_match = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
                if (m_match && !ov) begin
                    m_hist  = '0;
                    m_fill  = 0;
                    m_state = 1;
                end else begin
                    m_hist = nh;
                    if (m_state == 1) begin
                        m_fill++;
                        if (m_fill == PAT_LEN) m_state = 2;
                    end
                end
            end
        end
    endtask

    // Drive one cycle, push the model's post-edge outputs, then check them.
    task automatic step(input logic l, input logic [PAT_LEN-1:0] p,
                        input logic ov, input logic v, input logic b,
                        input string tag);
        exp_t e;
        load_pat   = l;
        pattern    = p;
        overlap_en = ov;
        in_valid   = v;
        in_bit     = b;
        model_step(l, p, ov, v, b);
        e.match = m_match;
        e.cnt   = m_cnt;
        e.sat   = (m_cnt == CNT_MAX);
        e.armed = (m_state != 0);
        sbq.push_back(e);
        @(posedge clock);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_match"}, 32'(match), 32'(e.match));
            chk({tag, "_count"}, 32'(match_count), 32'(e.cnt));
            chk({tag, "_sat"},   32'(count_sat), 32'(e.sat));
            chk({tag, "_armed"}, 32'(armed), 32'(e.armed));
        end
    endtask

    task automatic send_bits(input logic [PAT_LEN-1:0] p, input logic ov,
                             input logic [15:0] bits, input int n,
                             input int gap, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, p, ov, 1'b1, bits[i], tag);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, ~p, ov, 1'b0, bits[i], {tag, "_gap"});
            end
        end
    endtask

    int pulses;

    initial begin
        model_reset();
        reset_b    = 1'b0;
        load_pat   = 1'b0;
        pattern    = '0;
        overlap_en = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        #12;
        chk("rst_match", 32'(match), 0);
        chk("rst_count", 32'(match_count), 0);
        chk("rst_sat",   32'(count_sat), 0);
        chk("rst_armed", 32'(armed), 0);
        reset_b = 1'b1;

        // Unarmed: random valid bits must be ignored.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b1011, 1'b1, 1'b1, 1'($urandom_range(0, 1)), "unarmed");
        end
        chk("unarmed_count", 32'(match_count), 0);

        // Overlapping: 1,0,1,1,0,1,1 gives two matches.
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, "t1_load");
        send_bits(4'b1011, 1'b1, 16'b1011011, 7, 0, "t1");
        chk("t1_final_count", 32'(match_count), 2);

        // Non-overlapping: same stream gives one match.
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, "t2_load");
        send_bits(4'b1011, 1'b0, 16'b1011011, 7, 0, "t2");
        chk("t2_final_count", 32'(match_count), 1);

        // Saturation on a run of ones.
        pulses = 0;
        step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, "t4_load");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, "t4");
            if (match) pulses++;
        end
        step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, "t4_idle");
        chk("t4_pulses", 32'(pulses), 5);
        chk("t4_final_count", 32'(match_count), 3);
        chk("t4_final_sat", 32'(count_sat), 1);

        // Asynchronous reset mid-stream.
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, "t5_load");
        send_bits(4'b1011, 1'b1, 16'b101, 3, 0, "t5_pre");
        #3;
        reset_b = 1'b0;
        model_reset();
        #1;
        chk("t5_async_match", 32'(match), 0);
        chk("t5_async_count", 32'(match_count), 0);
        chk("t5_async_armed", 32'(armed), 0);
        @(posedge clock);
        #3;
        reset_b = 1'b1;
        #3;
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, "t5_reload");
        send_bits(4'b1011, 1'b1, 16'b1011, 4, 0, "t5");
        chk("t5_final_count", 32'(match_count), 1);

        // Gapped input; pattern input changes without load are ignored.
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, "t6_load");
        send_bits(4'b1011, 1'b0, 16'b1011, 4, 2, "t6_gap");
        chk("t6_gap_count", 32'(match_count), 1);

        // A bit presented with load_pat is dropped.
        step(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, "t6_load_bit");
        send_bits(4'b0000, 1'b0, 16'b011, 3, 0, "t6_drop");
        chk("t6_drop_count", 32'(match_count), 0);
        send_bits(4'b0000, 1'b0, 16'b1011, 4, 0, "t6_after");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
